fetch_queue: RTL and testbench

- Parametrised instruction/PC buffer between fetch and decode; the successor to the single-entry IF/ID latch.
- Decouples fetch from decode stalls by holding up to DEPTH {instr, pc} pairs, with a valid/ready handshake on both sides.
- A branch-redirect flush discards all queued entries.
- When empty, presents the architectural NOP so decode sees a bubble.

---
 rtl/proc_pkg.sv | 13 +
 rtl/fq_ptr.sv | 36 +++
 rtl/fetch_queue.sv | 97 +++++++++
 tb/tb_fetch_queue.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared processor constants used by the front-end buffering blocks.
package proc_pkg;

    localparam int unsigned INSTR_W_DEF = 16;
    localparam int unsigned PC_W_DEF    = 16;
    localparam logic [15:0] NOP_INSTR   = 16'h0800;

    // Pointer width for a power-of-two queue, never narrower than one bit.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fq_ptr.sv
// Wrapping queue pointer with increment enable and synchronous clear.
module fq_ptr
    import proc_pkg::*;
#(
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] ptr
);

    logic [WIDTH-1:0] ptr_q, ptr_d;

    // Natural binary wrap relies on a power-of-two depth.
    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (inc) begin
            ptr_d = ptr_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction/PC queue with show-ahead output and flush on redirect.
module fetch_queue
    import proc_pkg::*;
#(
    parameter int unsigned        INSTR_W   = INSTR_W_DEF,
    parameter int unsigned        PC_W      = PC_W_DEF,
    parameter int unsigned        DEPTH     = 4,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(proc_pkg::NOP_INSTR)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [INSTR_W-1:0]         in_instr,
    input  logic [PC_W-1:0]            in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [INSTR_W-1:0]         out_instr,
    output logic [PC_W-1:0]            out_pc,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PTR_W = ptr_width(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned ENT_W = INSTR_W + PC_W;

    logic [ENT_W-1:0] storage [DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push, pop;

    // Both flags come from the count register only, so ready never sees out_ready.
    assign in_ready  = (count_q != CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    fq_ptr #(
        .WIDTH (PTR_W)
    ) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .inc   (pop),
        .ptr   (rd_ptr)
    );

    fq_ptr #(
        .WIDTH (PTR_W)
    ) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .inc   (push),
        .ptr   (wr_ptr)
    );

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else begin
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Storage is not reset; validity is carried entirely by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            storage[wr_ptr] <= {in_instr, in_pc};
        end
    end

    always_comb begin
        out_instr = NOP_INSTR;
        out_pc    = '0;
        if (out_valid) begin
            {out_instr, out_pc} = storage[rd_ptr];
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus randomized traffic vs a queue model.
module tb_fetch_queue;

    localparam int unsigned DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic [15:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_instr;
    logic [15:0] out_pc;
    logic        flush;
    logic [2:0]  count;

    int checks;
    int failures;

    // Reference model: FIFO of {instr, pc}.
    logic [31:0] mq[$];

    fetch_queue #(
        .INSTR_W   (16),
        .PC_W      (16),
        .DEPTH     (DEPTH),
        .NOP_INSTR (16'h0800)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_pc    (out_pc),
        .flush     (flush),
        .count     (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_step();
        bit can_push;
        bit can_pop;
        if (!rst_n || flush) begin
            mq.delete();
        end else begin
            can_push = in_valid && (mq.size() != DEPTH);
            can_pop  = out_ready && (mq.size() != 0);
            if (can_pop) void'(mq.pop_front());
            if (can_push) mq.push_back({in_instr, in_pc});
        end
    endtask

    // Advance one edge; inputs are stable across it, outputs sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if (out_valid !== 1'b0 || out_instr !== 16'h0800 || out_pc !== 16'h0000
            || count !== 3'd0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_initial: got v=%b i=%h pc=%h cnt=%0d rdy=%b want v=0 i=0800 pc=0 cnt=0 rdy=1",
                     out_valid, out_instr, out_pc, count, in_ready);
        end
        rst_n = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_instr = 16'h9000 + 16'(i);
            in_pc    = 16'h0100 + 16'(2 * i);
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (count !== 3'd3) begin
            failures++;
            $display("FAIL reset_prefill_count: got %0d want 3", count);
        end
        rst_n = 1'b0;
        #1;
        mq.delete();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_valid: got %b want 0", out_valid);
        end
        checks++;
        if (out_instr !== 16'h0800 || out_pc !== 16'h0000) begin
            failures++;
            $display("FAIL reset_mid_out: got %h/%h want 0800/0000", out_instr, out_pc);
        end
        checks++;
        if (count !== 3'd0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_count: got cnt=%0d rdy=%b want cnt=0 rdy=1", count, in_ready);
        end
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fill();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_instr = 16'hA001 + 16'(i);
            in_pc    = 16'h0002 + 16'(2 * i);
            tick();
        end
        checks++;
        if (count !== 3'd4 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL fill_full: got cnt=%0d rdy=%b want cnt=4 rdy=0", count, in_ready);
        end
        checks++;
        if (out_instr !== 16'hA001 || out_pc !== 16'h0002 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL fill_head: got %h/%h v=%b want A001/0002 v=1", out_instr, out_pc, out_valid);
        end
        in_instr = 16'hA005;
        in_pc    = 16'h000A;
        tick();
        in_valid = 1'b0;
        checks++;
        if (count !== 3'd4 || out_instr !== 16'hA001) begin
            failures++;
            $display("FAIL fill_refused: got cnt=%0d head=%h want cnt=4 head=A001", count, out_instr);
        end
    endtask

    task automatic test_drain();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_instr !== 16'hA001 + 16'(i)
                || out_pc !== 16'h0002 + 16'(2 * i)) begin
                failures++;
                $display("FAIL drain_%0d: got v=%b %h/%h want v=1 %h/%h", i, out_valid,
                         out_instr, out_pc, 16'hA001 + 16'(i), 16'h0002 + 16'(2 * i));
            end
            tick();
        end
        checks++;
        if (out_valid !== 1'b0 || out_instr !== 16'h0800 || out_pc !== 16'h0000 || count !== 3'd0) begin
            failures++;
            $display("FAIL drain_empty: got v=%b %h/%h cnt=%0d want v=0 0800/0000 cnt=0",
                     out_valid, out_instr, out_pc, count);
        end
        tick();
        checks++;
        if (count !== 3'd0) begin
            failures++;
            $display("FAIL drain_empty_pop_ignored: got cnt=%0d want 0", count);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_concurrent();
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_instr = 16'hB000 + 16'(i);
            in_pc    = 16'h0200 + 16'(i);
            tick();
        end
        out_ready = 1'b1;
        for (int j = 0; j < 6; j++) begin
            in_instr = 16'hB002 + 16'(j);
            in_pc    = 16'h0202 + 16'(j);
            checks++;
            if (count !== 3'd2 || out_instr !== 16'hB000 + 16'(j) || out_pc !== 16'h0200 + 16'(j)) begin
                failures++;
                $display("FAIL concurrent_%0d: got cnt=%0d %h/%h want cnt=2 %h/%h", j, count,
                         out_instr, out_pc, 16'hB000 + 16'(j), 16'h0200 + 16'(j));
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (count !== 3'd2 || out_instr !== 16'hB006) begin
            failures++;
            $display("FAIL concurrent_end: got cnt=%0d head=%h want cnt=2 head=B006", count, out_instr);
        end
    endtask

    task automatic test_flush();
        in_valid = 1'b1;
        in_instr = 16'hB0FF;
        in_pc    = 16'h02FF;
        tick();
        checks++;
        if (count !== 3'd3) begin
            failures++;
            $display("FAIL flush_pre_count: got %0d want 3", count);
        end
        flush     = 1'b1;
        out_ready = 1'b1;
        in_instr  = 16'hC0DE;
        in_pc     = 16'h0300;
        tick();
        flush     = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0 || out_instr !== 16'h0800) begin
            failures++;
            $display("FAIL flush_empty: got cnt=%0d v=%b i=%h want cnt=0 v=0 i=0800",
                     count, out_valid, out_instr);
        end
        in_valid = 1'b1;
        in_instr = 16'hD123;
        in_pc    = 16'h0400;
        tick();
        in_valid = 1'b0;
        checks++;
        if (count !== 3'd1 || out_instr !== 16'hD123 || out_pc !== 16'h0400) begin
            failures++;
            $display("FAIL flush_next_head: got cnt=%0d %h/%h want cnt=1 D123/0400",
                     count, out_instr, out_pc);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_full_pop();
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_instr = 16'hE001 + 16'(i);
            in_pc    = 16'h0500 + 16'(i);
            tick();
        end
        in_instr  = 16'hE005;
        in_pc     = 16'h0504;
        out_ready = 1'b1;
        tick();
        checks++;
        if (count !== 3'd3 || out_instr !== 16'hE002) begin
            failures++;
            $display("FAIL full_pop_refused: got cnt=%0d head=%h want cnt=3 head=E002", count, out_instr);
        end
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        checks++;
        if (count !== 3'd4 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL full_pop_accept: got cnt=%0d rdy=%b want cnt=4 rdy=0", count, in_ready);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_instr !== 16'hE002 + 16'(i)) begin
                failures++;
                $display("FAIL full_pop_drain_%0d: got %h want %h", i, out_instr, 16'hE002 + 16'(i));
            end
            tick();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        logic        exp_v;
        logic        exp_r;
        logic [2:0]  exp_c;
        logic [15:0] exp_i;
        logic [15:0] exp_p;
        for (int n = 0; n < 500; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) == 0) ^ (n >= 250);
            flush     = ($urandom_range(0, 19) == 0);
            in_instr  = 16'($urandom);
            in_pc     = 16'($urandom);
            #1;
            exp_v = (mq.size() != 0);
            exp_r = (mq.size() != DEPTH);
            exp_c = 3'(mq.size());
            exp_i = exp_v ? mq[0][31:16] : 16'h0800;
            exp_p = exp_v ? mq[0][15:0] : 16'h0000;
            checks++;
            if ({out_valid, in_ready, count, out_instr, out_pc} !== {exp_v, exp_r, exp_c, exp_i, exp_p}) begin
                failures++;
                $display("FAIL random_%0d: got v=%b r=%b c=%0d %h/%h want v=%b r=%b c=%0d %h/%h", n,
                         out_valid, in_ready, count, out_instr, out_pc,
                         exp_v, exp_r, exp_c, exp_i, exp_p);
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        #2;
        test_reset();
        test_fill();
        test_drain();
        test_concurrent();
        test_flush();
        test_full_pop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
